cs_window_filter: RTL

- Parametrised successor to the fixed 9-tap, 8-bit CS series-computation block.
- Keeps a sliding window of the last WIN accepted samples and finds X_appr, the largest window sample not greater than the window average.
- Mode 0 outputs Y = (sum + WIN*X_appr) >> OUT_SHIFT. Mode 1 outputs X_appr.
- Adds input/output valid qualification, a flush, and fill tracking. Sits in the datapath in place of the original CS block, feeding downstream consumers that sample on out_valid.

---
 rtl/cs_window_filter.sv | 101 ++++++++++
 1 files changed

// File: rtl/cs_window_filter.sv
// Sliding-window CS filter: Y = (sum + WIN*X_appr) >> OUT_SHIFT (mode 0) or X_appr (mode 1).
// One cycle from accept edge to out_valid; no backpressure, one result per accepted sample once full.
module cs_window_filter #(
   parameter int DATA_W    = 8,
   parameter int WIN       = 9,
   parameter int OUT_SHIFT = 3,
   parameter int OUT_W     = 10
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in_valid,
   input  logic [DATA_W-1:0]            X,
   input  logic                         mode,
   input  logic                         flush,
   output logic                         out_valid,
   output logic [OUT_W-1:0]             Y,
   output logic [$clog2(WIN+1)-1:0]     fill
);

   localparam int FILL_W = $clog2(WIN+1);
   localparam int SUM_W  = DATA_W + $clog2(WIN);
   localparam int FULL_W = (SUM_W + 1 > OUT_W) ? SUM_W + 1 : OUT_W;

   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(WIN);
   localparam logic [SUM_W-1:0]  WIN_S    = SUM_W'(WIN);
   localparam logic [FULL_W-1:0] WIN_F    = FULL_W'(WIN);

   // Entry 0 holds the newest sample, entry WIN-1 the oldest.
   logic [WIN-1:0][DATA_W-1:0] win_q, win_d, base_win;
   logic [SUM_W-1:0]           sum_q, sum_d, base_sum;
   logic [FILL_W-1:0]          fill_q, fill_d, base_fill;
   logic                       mode_q, mode_d;
   logic                       s1_vld_q, s1_vld_d;
   logic                       out_valid_q, out_valid_d;
   logic [OUT_W-1:0]           y_q, y_d;

   logic [DATA_W-1:0]          x_appr;
   logic [SUM_W-1:0]           prod;
   logic [FULL_W-1:0]          full;
   logic [OUT_W-1:0]           res;

   // Stage 1: window shift, running sum and fill; flush clears before a same-edge load.
   always_comb begin
      base_win  = flush ? '0 : win_q;
      base_sum  = flush ? '0 : sum_q;
      base_fill = flush ? '0 : fill_q;
      win_d     = base_win;
      sum_d     = base_sum;
      fill_d    = base_fill;
      mode_d    = mode_q;
      s1_vld_d  = 1'b0;
      if (in_valid) begin
         win_d    = {base_win[WIN-2:0], X};
         sum_d    = base_sum + SUM_W'(X) - SUM_W'(base_win[WIN-1]);
         fill_d   = (base_fill == FILL_MAX) ? FILL_MAX : base_fill + FILL_W'(1);
         mode_d   = mode;
         s1_vld_d = (fill_d == FILL_MAX);
      end
   end

   // Stage 2: entry*WIN <= sum stands in for entry <= average without a divider.
   always_comb begin
      x_appr = '0;
      prod   = '0;
      for (int i = 0; i < WIN; i++) begin
         prod = SUM_W'(win_q[i]) * WIN_S;
         if ((prod <= sum_q) && (win_q[i] > x_appr)) begin
            x_appr = win_q[i];
         end
      end
      full        = FULL_W'(sum_q) + FULL_W'(x_appr) * WIN_F;
      res         = mode_q ? OUT_W'(x_appr) : OUT_W'(full >> OUT_SHIFT);
      out_valid_d = s1_vld_q & ~flush;
      y_d         = out_valid_d ? res : y_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         win_q       <= '0;
         sum_q       <= '0;
         fill_q      <= '0;
         mode_q      <= 1'b0;
         s1_vld_q    <= 1'b0;
         out_valid_q <= 1'b0;
         y_q         <= '0;
      end else begin
         win_q       <= win_d;
         sum_q       <= sum_d;
         fill_q      <= fill_d;
         mode_q      <= mode_d;
         s1_vld_q    <= s1_vld_d;
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
      end
   end

   assign out_valid = out_valid_q;
   assign Y         = y_q;
   assign fill      = fill_q;

endmodule
